// File: rtl/frame_render_sequencer.sv
// Per-frame sequencer: takes one descriptor from the MCU, waits for a display
// frame boundary, clears the framebuffer, then starts the render pipeline
// once per object and counts completions. It reports the end of each frame
// with a pulse and keeps a wrapping count of completed frames.
module frame_render_sequencer #(
  parameter int MAX_NUM_OBJECTS_PER_FRAME = 1024,
  parameter int OBJ_COUNT_WIDTH           = $clog2(MAX_NUM_OBJECTS_PER_FRAME + 1),
  parameter int FRAME_COUNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_mcu_dv,
  input  logic [OBJ_COUNT_WIDTH-1:0]   i_mcu_num_objects,
  output logic                         o_mcu_ready,
  input  logic                         i_frame,
  output logic                         o_clear,
  input  logic                         i_display_ready,
  output logic                         o_rp_start,
  input  logic                         i_rp_ready,
  input  logic                         i_rp_finished,
  output logic [OBJ_COUNT_WIDTH-1:0]   o_obj_index,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic [FRAME_COUNT_WIDTH-1:0] o_frames_rendered
);

  localparam logic [OBJ_COUNT_WIDTH-1:0]   OBJ_MAX  = OBJ_COUNT_WIDTH'(MAX_NUM_OBJECTS_PER_FRAME);
  localparam logic [OBJ_COUNT_WIDTH-1:0]   OBJ_ZERO = {OBJ_COUNT_WIDTH{1'b0}};
  localparam logic [OBJ_COUNT_WIDTH-1:0]   OBJ_ONE  = {{(OBJ_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FRAME_COUNT_WIDTH-1:0] FRM_ZERO = {FRAME_COUNT_WIDTH{1'b0}};
  localparam logic [FRAME_COUNT_WIDTH-1:0] FRM_ONE  = {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_AWAIT_MCU  = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_CLEAR      = 3'd3,
    S_CLEAR_WAIT = 3'd4,
    S_START_OBJ  = 3'd5,
    S_RENDER     = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t                         state_r;
  state_t                         state_s;
  logic [OBJ_COUNT_WIDTH-1:0]     count_r;
  logic [OBJ_COUNT_WIDTH-1:0]     count_s;
  logic [OBJ_COUNT_WIDTH-1:0]     obj_index_s;
  logic                           clear_seen_low_r;
  logic                           clear_seen_low_s;
  logic                           last_obj_s;
  logic                           mcu_ready_s;
  logic                           clear_s;
  logic                           rp_start_s;
  logic                           busy_s;
  logic                           frame_done_s;
  logic [FRAME_COUNT_WIDTH-1:0]   frames_s;

  // The object currently in flight is the last one of the frame.
  assign last_obj_s = (o_obj_index == (count_r - OBJ_ONE));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; events outside their owning state are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_rp_ready) state_s = S_AWAIT_MCU;
        else            state_s = state_r;
      end
      S_AWAIT_MCU: begin
        if (i_mcu_dv) state_s = S_WAIT_FRAME;
        else          state_s = state_r;
      end
      S_WAIT_FRAME: begin
        if (i_frame) state_s = S_CLEAR;
        else         state_s = state_r;
      end
      S_CLEAR: begin
        state_s = S_CLEAR_WAIT;
      end
      S_CLEAR_WAIT: begin
        // Clear is complete only after ready has been seen low then high again.
        if (clear_seen_low_r && i_display_ready) begin
          if (count_r == OBJ_ZERO) state_s = S_DONE;
          else                     state_s = S_START_OBJ;
        end else begin
          state_s = state_r;
        end
      end
      S_START_OBJ: begin
        if (i_rp_ready) state_s = S_RENDER;
        else            state_s = state_r;
      end
      S_RENDER: begin
        if (i_rp_finished) begin
          if (last_obj_s) state_s = S_DONE;
          else            state_s = S_START_OBJ;
        end else begin
          state_s = state_r;
        end
      end
      S_DONE: begin
        state_s = S_AWAIT_MCU;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Next values of the datapath and of the registered outputs.
  always_comb begin
    count_s          = count_r;
    obj_index_s      = o_obj_index;
    clear_seen_low_s = clear_seen_low_r;
    frames_s         = o_frames_rendered;
    case (state_r)
      S_AWAIT_MCU: begin
        if (i_mcu_dv) begin
          count_s     = (i_mcu_num_objects > OBJ_MAX) ? OBJ_MAX : i_mcu_num_objects;
          obj_index_s = OBJ_ZERO;
        end else begin
          count_s     = count_r;
        end
      end
      S_CLEAR: begin
        clear_seen_low_s = 1'b0;
      end
      S_CLEAR_WAIT: begin
        if (!i_display_ready) clear_seen_low_s = 1'b1;
        else                  clear_seen_low_s = clear_seen_low_r;
      end
      S_RENDER: begin
        // The last object keeps its index so it stays visible after the frame.
        if (i_rp_finished && !last_obj_s) obj_index_s = o_obj_index + OBJ_ONE;
        else                              obj_index_s = o_obj_index;
      end
      default: begin
        count_s = count_r;
      end
    endcase
    if (state_s == S_DONE) frames_s = o_frames_rendered + FRM_ONE;
    else                   frames_s = o_frames_rendered;
    mcu_ready_s  = (state_s == S_AWAIT_MCU);
    clear_s      = (state_s == S_CLEAR);
    rp_start_s   = (state_r == S_START_OBJ) && (state_s == S_RENDER);
    busy_s       = (state_s != S_IDLE) && (state_s != S_AWAIT_MCU);
    frame_done_s = (state_s == S_DONE);
  end

  // Output and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r           <= OBJ_ZERO;
      clear_seen_low_r  <= 1'b0;
      o_obj_index       <= OBJ_ZERO;
      o_frames_rendered <= FRM_ZERO;
      o_mcu_ready       <= 1'b0;
      o_clear           <= 1'b0;
      o_rp_start        <= 1'b0;
      o_busy            <= 1'b0;
      o_frame_done      <= 1'b0;
    end else begin
      count_r           <= count_s;
      clear_seen_low_r  <= clear_seen_low_s;
      o_obj_index       <= obj_index_s;
      o_frames_rendered <= frames_s;
      o_mcu_ready       <= mcu_ready_s;
      o_clear           <= clear_s;
      o_rp_start        <= rp_start_s;
      o_busy            <= busy_s;
      o_frame_done      <= frame_done_s;
    end
  end

endmodule

// File: tb/tb_frame_render_sequencer.sv
// Directed bench for frame_render_sequencer. A display model answers each
// clear by dropping ready for two cycles; a pipeline model answers each start
// with a finished pulse rp_lat cycles later. A second instance with a 6-bit
// frame counter shares all inputs and shows the counter wrap cheaply.
module tb_frame_render_sequencer;

  logic        clk;
  logic        rstn;
  logic        i_mcu_dv;
  logic [10:0] i_mcu_num_objects;
  logic        i_frame;
  logic        i_display_ready;
  logic        i_rp_ready;
  logic        i_rp_finished;
  logic        auto_fin;
  logic        man_fin;

  logic        o_mcu_ready, o_clear, o_rp_start, o_busy, o_frame_done;
  logic [10:0] o_obj_index;
  logic [15:0] o_frames_rendered;

  logic        w_mcu_ready, w_clear, w_rp_start, w_busy, w_frame_done;
  logic [10:0] w_obj_index;
  logic [5:0]  w_frames_rendered;

  int errors = 0;
  int checks = 0;

  int rp_lat = 10;
  int fin_cd = 0;
  int disp_cd = 0;

  int clear_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  logic prev_pulse = 1'b0;
  logic [10:0] idx_log [0:4095];

  assign i_rp_finished = auto_fin | man_fin;

  frame_render_sequencer dut (
    .clk(clk), .rstn(rstn),
    .i_mcu_dv(i_mcu_dv), .i_mcu_num_objects(i_mcu_num_objects), .o_mcu_ready(o_mcu_ready),
    .i_frame(i_frame), .o_clear(o_clear), .i_display_ready(i_display_ready),
    .o_rp_start(o_rp_start), .i_rp_ready(i_rp_ready), .i_rp_finished(i_rp_finished),
    .o_obj_index(o_obj_index), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frames_rendered(o_frames_rendered)
  );

  frame_render_sequencer #(.FRAME_COUNT_WIDTH(6)) dut_w (
    .clk(clk), .rstn(rstn),
    .i_mcu_dv(i_mcu_dv), .i_mcu_num_objects(i_mcu_num_objects), .o_mcu_ready(w_mcu_ready),
    .i_frame(i_frame), .o_clear(w_clear), .i_display_ready(i_display_ready),
    .o_rp_start(w_rp_start), .i_rp_ready(i_rp_ready), .i_rp_finished(i_rp_finished),
    .o_obj_index(w_obj_index), .o_busy(w_busy), .o_frame_done(w_frame_done),
    .o_frames_rendered(w_frames_rendered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline model: finished pulse rp_lat cycles after each start.
  always @(negedge clk) begin
    if (!rstn) begin
      fin_cd   <= 0;
      auto_fin <= 1'b0;
    end else begin
      auto_fin <= 1'b0;
      if (o_rp_start) begin
        fin_cd <= rp_lat;
      end else if (fin_cd != 0) begin
        fin_cd <= fin_cd - 1;
        if (fin_cd == 1) auto_fin <= 1'b1;
      end
    end
  end

  // Display model: ready drops for two cycles after each clear.
  always @(negedge clk) begin
    if (!rstn) begin
      disp_cd         <= 0;
      i_display_ready <= 1'b1;
    end else if (o_clear) begin
      disp_cd         <= 2;
      i_display_ready <= 1'b0;
    end else if (disp_cd != 0) begin
      disp_cd <= disp_cd - 1;
      if (disp_cd == 1) i_display_ready <= 1'b1;
    end
  end

  // Pulse monitor: counts pulses, logs start indices, flags adjacent pulses.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_clear) clear_cnt <= clear_cnt + 1;
      if (o_rp_start) begin
        if (start_cnt < 4096) idx_log[start_cnt] <= o_obj_index;
        start_cnt <= start_cnt + 1;
      end
      if (o_frame_done) done_cnt <= done_cnt + 1;
      if ((o_clear && o_rp_start) || (prev_pulse && (o_clear || o_rp_start)))
        overlap_cnt <= overlap_cnt + 1;
      prev_pulse <= o_clear | o_rp_start;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    int i = 0;
    while (!o_mcu_ready && i < budget) begin
      tick();
      i++;
    end
    ok = o_mcu_ready;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int i = 0;
    while (done_cnt < target && i < budget) begin
      tick();
      i++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic run_frame(input logic [10:0] num, input int budget, output bit ok);
    bit ok1, ok2;
    int tgt;
    tgt = done_cnt + 1;
    wait_ready(50, ok1);
    i_mcu_dv = 1'b1;
    i_mcu_num_objects = num;
    tick();
    i_mcu_dv = 1'b0;
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    wait_done(tgt, budget, ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    i_rp_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_mcu_ready, o_clear, o_rp_start, o_busy, o_frame_done} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {o_mcu_ready, o_clear, o_rp_start, o_busy, o_frame_done});
    end
    checks++;
    if (o_obj_index !== 11'd0 || o_frames_rendered !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: got idx=%0d frames=%0d expected 0 0", o_obj_index, o_frames_rendered);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (o_mcu_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_await: got ready=%b busy=%b expected 1 0", o_mcu_ready, o_busy);
    end
  endtask

  task automatic test_basic;
    int bc, bs, bd;
    bit ok;
    bc = clear_cnt; bs = start_cnt; bd = done_cnt;
    wait_ready(20, ok);
    i_mcu_dv = 1'b1;
    i_mcu_num_objects = 11'd3;
    tick();
    i_mcu_dv = 1'b0;
    checks++;
    if (o_mcu_ready !== 1'b0 || o_busy !== 1'b1 || o_obj_index !== 11'd0) begin
      errors++;
      $display("FAIL basic_accept: got ready=%b busy=%b idx=%0d expected 0 1 0", o_mcu_ready, o_busy, o_obj_index);
    end
    tick(); tick(); tick();
    checks++;
    if (o_clear !== 1'b0 || clear_cnt != bc) begin
      errors++;
      $display("FAIL basic_wait_frame: got clear=%b clears=%0d expected 0 0", o_clear, clear_cnt - bc);
    end
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    checks++;
    if (o_clear !== 1'b1) begin
      errors++;
      $display("FAIL basic_clear_pulse: got %b expected 1", o_clear);
    end
    tick();
    checks++;
    if (o_clear !== 1'b0) begin
      errors++;
      $display("FAIL basic_clear_width: got %b expected 0", o_clear);
    end
    wait_done(bd + 1, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: got no frame_done expected one within 300 cycles");
    end
    checks++;
    if (clear_cnt - bc != 1 || start_cnt - bs != 3 || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL basic_pulses: got clears=%0d starts=%0d dones=%0d expected 1 3 1",
               clear_cnt - bc, start_cnt - bs, done_cnt - bd);
    end
    checks++;
    if (idx_log[bs] !== 11'd0 || idx_log[bs+1] !== 11'd1 || idx_log[bs+2] !== 11'd2) begin
      errors++;
      $display("FAIL basic_indices: got %0d %0d %0d expected 0 1 2", idx_log[bs], idx_log[bs+1], idx_log[bs+2]);
    end
    checks++;
    if (o_frames_rendered !== 16'd1 || o_obj_index !== 11'd2 || o_mcu_ready !== 1'b1 || o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: got frames=%0d idx=%0d ready=%b done=%b expected 1 2 1 0",
               o_frames_rendered, o_obj_index, o_mcu_ready, o_frame_done);
    end
  endtask

  task automatic test_zero_objects;
    int bc, bs, bd;
    bit ok;
    bc = clear_cnt; bs = start_cnt; bd = done_cnt;
    run_frame(11'd0, 100, ok);
    checks++;
    if (!ok || clear_cnt - bc != 1 || start_cnt - bs != 0 || done_cnt - bd != 1) begin
      errors++;
      $display("FAIL zero_frame: got ok=%b clears=%0d starts=%0d dones=%0d expected 1 1 0 1",
               ok, clear_cnt - bc, start_cnt - bs, done_cnt - bd);
    end
    checks++;
    if (o_frames_rendered !== 16'd2) begin
      errors++;
      $display("FAIL zero_frames_rendered: got %0d expected 2", o_frames_rendered);
    end
  endtask

  task automatic test_stray_events;
    int bc, bs, bd;
    bit ok;
    bc = clear_cnt; bs = start_cnt; bd = done_cnt;
    wait_ready(20, ok);
    man_fin = 1'b1;
    i_frame = 1'b1;
    tick();
    man_fin = 1'b0;
    i_frame = 1'b0;
    tick();
    checks++;
    if (o_mcu_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_hold_await: got ready=%b busy=%b expected 1 0", o_mcu_ready, o_busy);
    end
    // Frame pulse in the acceptance cycle, then a changed count while dv stays high.
    i_mcu_dv = 1'b1;
    i_mcu_num_objects = 11'd1;
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    i_mcu_num_objects = 11'd5;
    tick(); tick(); tick(); tick();
    i_mcu_dv = 1'b0;
    tick(); tick();
    checks++;
    if (o_mcu_ready !== 1'b0 || o_busy !== 1'b1 || clear_cnt != bc) begin
      errors++;
      $display("FAIL stray_wait_frame: got ready=%b busy=%b clears=%0d expected 0 1 0",
               o_mcu_ready, o_busy, clear_cnt - bc);
    end
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    wait_done(bd + 1, 300, ok);
    checks++;
    if (!ok || start_cnt - bs != 1 || done_cnt - bd != 1 || o_frames_rendered !== 16'd3) begin
      errors++;
      $display("FAIL stray_one_descriptor: got ok=%b starts=%0d dones=%0d frames=%0d expected 1 1 1 3",
               ok, start_cnt - bs, done_cnt - bd, o_frames_rendered);
    end
  endtask

  task automatic test_saturate;
    int bs;
    bit ok;
    bs = start_cnt;
    rp_lat = 2;
    run_frame(11'd2000, 20000, ok);
    rp_lat = 10;
    checks++;
    if (!ok || start_cnt - bs != 1024) begin
      errors++;
      $display("FAIL sat_starts: got ok=%b starts=%0d expected 1 1024", ok, start_cnt - bs);
    end
    checks++;
    if (idx_log[bs+1023] !== 11'd1023 || o_obj_index !== 11'd1023) begin
      errors++;
      $display("FAIL sat_index: got logged=%0d idx=%0d expected 1023 1023", idx_log[bs+1023], o_obj_index);
    end
    checks++;
    if (o_frames_rendered !== 16'd4) begin
      errors++;
      $display("FAIL sat_frames: got %0d expected 4", o_frames_rendered);
    end
  endtask

  task automatic test_reset_mid_frame;
    int bs, i, rc, rs;
    bit ok;
    bs = start_cnt;
    wait_ready(20, ok);
    i_mcu_dv = 1'b1;
    i_mcu_num_objects = 11'd4;
    tick();
    i_mcu_dv = 1'b0;
    i_frame = 1'b1;
    tick();
    i_frame = 1'b0;
    i = 0;
    while (start_cnt < bs + 2 && i < 200) begin
      tick();
      i++;
    end
    checks++;
    if (start_cnt < bs + 2) begin
      errors++;
      $display("FAIL rst_reach_obj1: got starts=%0d expected 2 within 200 cycles", start_cnt - bs);
    end
    tick(); tick(); tick();
    checks++;
    if (o_obj_index !== 11'd1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_render: got idx=%0d busy=%b expected 1 1", o_obj_index, o_busy);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_mcu_ready, o_clear, o_rp_start, o_busy, o_frame_done} !== 5'b00000 ||
        o_obj_index !== 11'd0 || o_frames_rendered !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: got flags=%b idx=%0d frames=%0d expected 00000 0 0",
               {o_mcu_ready, o_clear, o_rp_start, o_busy, o_frame_done}, o_obj_index, o_frames_rendered);
    end
    rc = clear_cnt; rs = start_cnt;
    i_rp_ready = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    checks++;
    if (o_mcu_ready !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_gate: got ready=%b busy=%b expected 0 0", o_mcu_ready, o_busy);
    end
    i_rp_ready = 1'b1;
    tick();
    checks++;
    if (o_mcu_ready !== 1'b1 || o_frames_rendered !== 16'd0) begin
      errors++;
      $display("FAIL rst_await: got ready=%b frames=%0d expected 1 0", o_mcu_ready, o_frames_rendered);
    end
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (clear_cnt != rc || start_cnt != rs || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: got clears=%0d starts=%0d busy=%b expected 0 0 0",
               clear_cnt - rc, start_cnt - rs, o_busy);
    end
  endtask

  task automatic test_frame_wrap;
    int timeouts = 0;
    bit ok;
    for (int f = 0; f < 63; f++) begin
      run_frame(11'd0, 100, ok);
      if (!ok) timeouts++;
    end
    checks++;
    if (timeouts != 0 || w_frames_rendered !== 6'd63 || o_frames_rendered !== 16'd63) begin
      errors++;
      $display("FAIL wrap_preload: got timeouts=%0d narrow=%0d wide=%0d expected 0 63 63",
               timeouts, w_frames_rendered, o_frames_rendered);
    end
    run_frame(11'd0, 100, ok);
    checks++;
    if (!ok || w_frames_rendered !== 6'd0 || o_frames_rendered !== 16'd64) begin
      errors++;
      $display("FAIL wrap_rollover: got ok=%b narrow=%0d wide=%0d expected 1 0 64",
               ok, w_frames_rendered, o_frames_rendered);
    end
  endtask

  task automatic test_pulse_spacing;
    checks++;
    if (overlap_cnt != 0) begin
      errors++;
      $display("FAIL pulse_spacing: got %0d adjacent or overlapping pulses expected 0", overlap_cnt);
    end
  endtask

  initial begin
    rstn = 1'b0;
    i_mcu_dv = 1'b0;
    i_mcu_num_objects = 11'd0;
    i_frame = 1'b0;
    i_rp_ready = 1'b1;
    man_fin = 1'b0;
    test_reset();
    test_basic();
    test_zero_objects();
    test_stray_events();
    test_saturate();
    test_reset_mid_frame();
    test_frame_wrap();
    test_pulse_spacing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_render_sequencer.md
Name: frame_render_sequencer

Overview:
- Per-frame controller for the render pipeline and display clear.
- Accepts a frame descriptor (object count) from the MCU interface.
- Waits for a display frame boundary, clears the framebuffer, then issues one render-pipeline start per object and counts completions.
- Signals frame completion; sits between the MCU/FIFO front end, render_pipeline start/ready/finished, and display clear/ready.

Parameters:
- MAX_NUM_OBJECTS_PER_FRAME, 1024, maximum objects rendered per frame.
- OBJ_COUNT_WIDTH, $clog2(MAX_NUM_OBJECTS_PER_FRAME+1) = 11, width of object count and index.
- FRAME_COUNT_WIDTH, 16, width of completed-frame counter.

Ports:
- clk  in  1  system clock (render clock domain).
- rstn  in  1  reset; asynchronous and active-low.
- i_mcu_dv  in  1  frame descriptor valid.
- i_mcu_num_objects  in  OBJ_COUNT_WIDTH  objects in this frame.
- o_mcu_ready  out  1  sequencer accepts a descriptor.
- i_frame  in  1  display frame-start pulse, already synchronous to clk.
- o_clear  out  1  framebuffer/depth clear request pulse.
- i_display_ready  in  1  display idle (clear complete).
- o_rp_start  out  1  render pipeline start pulse.
- i_rp_ready  in  1  render pipeline ready.
- i_rp_finished  in  1  render pipeline object-finished pulse.
- o_obj_index  out  OBJ_COUNT_WIDTH  index of the object being rendered.
- o_busy  out  1  high in every state except IDLE and AWAIT_MCU.
- o_frame_done  out  1  one-cycle pulse when a frame completes.
- o_frames_rendered  out  FRAME_COUNT_WIDTH  completed-frame counter.

Behaviour:
- All outputs are registered.
- Reset (rstn low, asynchronous): state=IDLE; all outputs 0; internal count=0; clear_seen_low=0. Reset mid-frame abandons the frame; no start or clear pulse is emitted.
- States and transitions:
  - IDLE: when i_rp_ready=1 -> AWAIT_MCU.
  - AWAIT_MCU: o_mcu_ready=1. When i_mcu_dv=1, latch count = min(i_mcu_num_objects, MAX_NUM_OBJECTS_PER_FRAME), set o_obj_index=0 -> WAIT_FRAME. o_mcu_ready drops the next cycle, so exactly one descriptor is taken per frame.
  - WAIT_FRAME: when i_frame=1 -> CLEAR. A pulse arriving in the same cycle as acceptance in AWAIT_MCU is not counted.
  - CLEAR: o_clear=1 for exactly one cycle, clear_seen_low=0 -> CLEAR_WAIT.
  - CLEAR_WAIT:
    - Set clear_seen_low when i_display_ready=0.
    - When clear_seen_low=1 and i_display_ready=1: go to DONE if count==0, else START_OBJ.
    - A ready that never drops holds the state indefinitely; this is the documented hang point.
  - START_OBJ: when i_rp_ready=1, o_rp_start=1 for exactly one cycle (the cycle after ready is sampled) -> RENDER.
  - RENDER: on i_rp_finished=1:
    - If o_obj_index==count-1 -> DONE, and o_obj_index holds its value.
    - Else o_obj_index+1 -> START_OBJ.
  - DONE: o_frame_done=1 for one cycle; o_frames_rendered+1, wrapping at 2^FRAME_COUNT_WIDTH -> AWAIT_MCU.
- Ignored events:
  - i_rp_finished outside RENDER.
  - i_mcu_dv outside AWAIT_MCU.
  - i_frame outside WAIT_FRAME.
  - Multiple finished pulses within RENDER count once, since RENDER exits on the first.
- Minimum per-object overhead is 2 cycles (START_OBJ plus the start pulse) beyond pipeline latency.
- o_rp_start and o_clear are never high simultaneously, and never high in consecutive cycles.
- Any unreachable state encoding returns to IDLE.

Test Plan:
- Reset with i_rp_ready=1; descriptor of 3 objects; i_frame pulse; display ready drops 2 cycles then rises; finished returns 10 cycles after each start -> one o_clear pulse, 3 o_rp_start pulses, o_obj_index 0,1,2, one o_frame_done, o_frames_rendered=1.
- Descriptor of 0 objects -> o_clear pulses, no o_rp_start, o_frame_done after clear completes.
- Descriptor of 2000 objects -> saturates to 1024 starts; o_obj_index reaches 1023.
- i_rp_finished and i_frame pulsed while in AWAIT_MCU; i_mcu_dv held high for 5 cycles -> no state advance from the stray pulses; only one descriptor latched.
- rstn asserted in RENDER at object 1 of 4 -> all outputs 0 immediately (asynchronously); after release the FSM passes through IDLE and AWAIT_MCU; o_frames_rendered=0.
- Preload o_frames_rendered at 65535 via 65535 zero-object frames, then one more frame -> counter wraps to 0.
